// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: channel structs, opcode enums and the default A-channel user field.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  // instr_type 4'h9 marks a data (non-instruction) access
  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    instr_type: 4'h9,
    cmd_intg:   7'h00,
    data_intg:  7'h00
  };

  typedef struct packed {
    logic                  a_valid;
    tl_a_op_e              a_opcode;
    logic [2:0]            a_param;
    logic [TL_SZW-1:0]     a_size;
    logic [TL_AIW-1:0]     a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DBW-1:0]     a_mask;
    logic [TL_DW-1:0]      a_data;
    tl_a_user_t            a_user;
    logic                  d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                  d_valid;
    tl_d_op_e              d_opcode;
    logic [2:0]            d_param;
    logic [TL_SZW-1:0]     d_size;
    logic [TL_AIW-1:0]     d_source;
    logic [TL_DIW-1:0]     d_sink;
    logic [TL_DW-1:0]      d_data;
    logic [13:0]           d_user;
    logic                  d_error;
    logic                  a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_adapter.sv
// Word-access host port to TL-UL bridge with a bounded number of in-flight requests
// and in-order response checking against the oldest outstanding source.
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int SourceW        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        proto_err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam int CntW = 3;

  logic [CntW-1:0]    count_q, count_d;
  logic [SourceW-1:0] issue_q, issue_d;
  logic [SourceW-1:0] retire_q, retire_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               proto_q, proto_d;

  logic               a_valid_s;
  logic               gnt_s;
  logic               resp_exp_s;
  logic               src_match_s;
  logic               unused_s;

  function automatic logic [SourceW-1:0] ptr_inc(input logic [SourceW-1:0] p);
    if (p == SourceW'(MaxOutstanding - 1)) begin
      return '0;
    end else begin
      return p + SourceW'(1);
    end
  endfunction

  // A-channel valid is gated by reset so nothing is presented while the block is held in reset
  assign a_valid_s   = req_i & (count_q < CntW'(MaxOutstanding)) & ~rst_i;
  assign gnt_s       = a_valid_s & tl_i.a_ready;
  assign resp_exp_s  = tl_i.d_valid & (count_q != CntW'(0));
  assign src_match_s = (tl_i.d_source == TL_AIW'(retire_q));
  assign gnt_o       = gnt_s;

  assign unused_s = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid_s;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = TL_SZW'(2);
    tl_o.a_source  = TL_AIW'(issue_q);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
    if (!we_i) begin
      tl_o.a_opcode = Get;
      tl_o.a_mask   = 4'hF;
      tl_o.a_data   = 32'h0;
    end else if (be_i == 4'hF) begin
      tl_o.a_opcode = PutFullData;
      tl_o.a_mask   = be_i;
      tl_o.a_data   = wdata_i;
    end else begin
      tl_o.a_opcode = PutPartialData;
      tl_o.a_mask   = be_i;
      tl_o.a_data   = wdata_i;
    end
  end

  always_comb begin
    count_d  = count_q;
    issue_d  = issue_q;
    retire_d = retire_q;
    rvalid_d = 1'b0;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    proto_d  = proto_q;

    case ({gnt_s, resp_exp_s})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (gnt_s) begin
      issue_d = ptr_inc(issue_q);
    end else begin
      issue_d = issue_q;
    end

    if (resp_exp_s) begin
      retire_d = ptr_inc(retire_q);
      rvalid_d = 1'b1;
      err_d    = tl_i.d_error | ~src_match_s;
      rdata_d  = (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : 32'h0;
      proto_d  = proto_q | ~src_match_s;
    end else if (tl_i.d_valid) begin
      // unsolicited beat: dropped, only flagged
      proto_d = 1'b1;
    end else begin
      proto_d = proto_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      issue_q  <= '0;
      retire_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      proto_q  <= proto_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign proto_err_o = proto_q;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed and randomized bench for tlul_host_adapter with a queue-based reference model.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  localparam int MO = 2;
  localparam int SW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err, proto;
  logic [31:0] rdata;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  always #5 clk = ~clk;

  tlul_host_adapter #(.MaxOutstanding(MO), .SourceW(SW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .proto_err_o(proto), .tl_o(tl_o), .tl_i(tl_i)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          q_src[$];
  bit          q_we[$];
  int          n_issued = 0;
  bit          m_rvalid = 0, m_err = 0, m_proto = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          last_gnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input bit v, input tl_d_op_e op, input int src, input logic [31:0] d,
                       input bit e);
    tl_i.d_valid  = v;
    tl_i.d_opcode = op;
    tl_i.d_source = 8'(src);
    tl_i.d_data   = d;
    tl_i.d_error  = e;
  endtask

  task automatic set_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b);
    req = r; we = w; addr = a; wdata = wd; be = b;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic tick();
    bit av, g, resp, mis;
    int src;
    tl_a_op_e eop;
    @(negedge clk);
    av = req && (q_src.size() < MO);
    g  = av && tl_i.a_ready;
    chk("a_valid", 32'(tl_o.a_valid), 32'(av));
    chk("gnt", 32'(gnt), 32'(g));
    chk("d_ready", 32'(tl_o.d_ready), 32'h1);
    if (av) begin
      if (!we) eop = Get;
      else if (be == 4'hF) eop = PutFullData;
      else eop = PutPartialData;
      chk("a_opcode", 32'(tl_o.a_opcode), 32'(eop));
      chk("a_size", 32'(tl_o.a_size), 32'd2);
      chk("a_address", tl_o.a_address, {addr[31:2], 2'b00});
      chk("a_mask", 32'(tl_o.a_mask), we ? 32'(be) : 32'hF);
      chk("a_data", tl_o.a_data, we ? wdata : 32'h0);
      chk("a_source", 32'(tl_o.a_source), 32'(n_issued % MO));
      chk("a_user", 32'(tl_o.a_user), 32'(TL_A_USER_DEFAULT));
    end
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    if (m_rvalid) begin
      chk("rdata", rdata, m_rdata);
      chk("err", 32'(err), 32'(m_err));
    end
    chk("proto_err", 32'(proto), 32'(m_proto));

    resp = tl_i.d_valid && (q_src.size() > 0);
    if (resp) begin
      src = q_src.pop_front();
      q_we.delete(0);
      mis = (32'(tl_i.d_source) != 32'(src));
      m_rvalid = 1;
      m_err = mis || tl_i.d_error;
      m_rdata = (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : 32'h0;
      if (mis) m_proto = 1;
    end else begin
      m_rvalid = 0;
      if (tl_i.d_valid) m_proto = 1;
    end
    if (g) begin
      q_src.push_back(n_issued % MO);
      q_we.push_back(we);
      n_issued++;
    end
    last_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b1;
    set_d(0, AccessAck, 0, 32'h0, 0);
    #1;
    chk("rst_a_valid", 32'(tl_o.a_valid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_proto", 32'(proto), 32'h0);
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b0;
    q_src.delete();
    q_we.delete();
    n_issued = 0;
    m_rvalid = 0; m_err = 0; m_rdata = 32'h0; m_proto = 0;
    last_gnt = 0;
  endtask

  initial begin
    int src;
    rst = 1'b1;
    tl_i = '0;
    tl_i.a_ready = 1'b1;
    set_req(0, 0, 32'h0, 32'h0, 4'h0);
    do_reset();
    tick();

    // single read
    set_req(1, 0, 32'h0000_1004, 32'h0, 4'h0);
    #1;
    chk("r032_opcode", 32'(tl_o.a_opcode), 32'(Get));
    chk("r032_source", 32'(tl_o.a_source), 32'h0);
    tick();
    req = 1'b0;
    set_d(1, AccessAckData, 0, 32'hDEAD_BEEF, 0);
    tick();
    chk("r032_rvalid", 32'(rvalid), 32'h1);
    chk("r032_rdata", rdata, 32'hDEAD_BEEF);
    chk("r032_err", 32'(err), 32'h0);
    set_d(0, AccessAck, 0, 32'h0, 0);
    tick();

    // partial write
    set_req(1, 1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    #1;
    chk("r033_opcode", 32'(tl_o.a_opcode), 32'(PutPartialData));
    chk("r033_mask", 32'(tl_o.a_mask), 32'h3);
    tick();
    req = 1'b0;
    set_d(1, AccessAck, 1, 32'hFFFF_FFFF, 0);
    tick();
    chk("r033_rvalid", 32'(rvalid), 32'h1);
    chk("r033_rdata", rdata, 32'h0);
    set_d(0, AccessAck, 0, 32'h0, 0);
    tick();

    // fill to MaxOutstanding with D held off
    set_req(1, 0, 32'h0000_3000, 32'h0, 4'h0);
    tick();
    tick();
    chk("r034_full_gnt", 32'(gnt), 32'h0);
    tick();
    set_d(1, AccessAckData, 0, 32'hA5A5_0001, 0);
    tick();
    set_d(0, AccessAck, 0, 32'h0, 0);
    #1;
    chk("r034_regnt", 32'(gnt), 32'h1);
    chk("r034_src", 32'(tl_o.a_source), 32'h0);
    tick();
    req = 1'b0;

    // simultaneous issue and retire at count 1
    set_d(1, AccessAckData, 1, 32'h0000_0011, 0);
    tick();
    set_req(1, 0, 32'h0000_4000, 32'h0, 4'h0);
    set_d(1, AccessAckData, 0, 32'h0000_0022, 0);
    tick();
    req = 1'b0;
    chk("r035_err", 32'(err), 32'h0);
    set_d(1, AccessAckData, 1, 32'h0000_0033, 0);
    tick();
    chk("r035_err2", 32'(err), 32'h0);
    chk("r035_rdata", rdata, 32'h0000_0033);
    set_d(0, AccessAck, 0, 32'h0, 0);
    tick();

    // d_error path, then unsolicited beat at count 0
    set_req(1, 0, 32'h0000_5000, 32'h0, 4'h0);
    tick();
    req = 1'b0;
    set_d(1, AccessAckData, 0, 32'h0, 1);
    tick();
    chk("r036_derr_err", 32'(err), 32'h1);
    chk("r036_derr_proto", 32'(proto), 32'h0);
    set_d(1, AccessAckData, 0, 32'h0, 0);
    tick();
    chk("r036_drop_rvalid", 32'(rvalid), 32'h0);
    chk("r036_drop_proto", 32'(proto), 32'h1);
    set_d(0, AccessAck, 0, 32'h0, 0);
    tick();

    // source mismatch
    do_reset();
    set_req(1, 0, 32'h0000_6000, 32'h0, 4'h0);
    tick();
    req = 1'b0;
    set_d(1, AccessAckData, 1, 32'h0000_0044, 0);
    tick();
    chk("r036_mis_err", 32'(err), 32'h1);
    chk("r036_mis_proto", 32'(proto), 32'h1);
    set_d(0, AccessAck, 0, 32'h0, 0);
    tick();

    // reset with two in flight, then a stale response
    do_reset();
    set_req(1, 0, 32'h0000_7000, 32'h0, 4'h0);
    tick();
    tick();
    req = 1'b0;
    tick();
    do_reset();
    set_d(1, AccessAckData, 0, 32'h0000_0055, 0);
    tick();
    chk("r037_rvalid", 32'(rvalid), 32'h0);
    chk("r037_proto", 32'(proto), 32'h1);
    set_d(0, AccessAck, 0, 32'h0, 0);
    set_req(1, 0, 32'h0000_8000, 32'h0, 4'h0);
    #1;
    chk("r037_src", 32'(tl_o.a_source), 32'h0);
    tick();
    req = 1'b0;

    // randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (!req || last_gnt) begin
        if ($urandom_range(0, 99) < 60) begin
          set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom));
        end else begin
          req = 1'b0;
        end
      end
      tl_i.a_ready = ($urandom_range(0, 3) != 0);
      if (q_src.size() > 0 && $urandom_range(0, 1) == 1) begin
        src = q_src[0];
        if ($urandom_range(0, 39) == 0) src = src ^ 1;
        set_d(1, q_we[0] ? AccessAck : AccessAckData, src, $urandom,
              ($urandom_range(0, 9) == 0));
      end else if (q_src.size() == 0 && $urandom_range(0, 99) == 0) begin
        set_d(1, AccessAckData, 0, $urandom, 0);
      end else begin
        set_d(0, AccessAck, 0, 32'h0, 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
